// File: rtl/ate_stream_if.sv
// Pixel-in / binary-out stream bundle for ate_stream.
// The source owns the in_* side and the engine owns the out_* side.
interface ate_stream_if #(
  parameter int PIX_W = 8
);
  // Valid-only stream, no ready: a pixel is taken on every rising edge with
  // in_valid high, and each out_valid cycle carries one result the sink must
  // take. Payload is meaningful only while its valid is high; bin, threshold
  // and frame_done are held at 0 whenever out_valid is low.
  logic             in_valid;
  logic [PIX_W-1:0] pix_data;
  logic             mode;
  logic             border_en;
  logic             out_valid;
  logic             bin;
  logic [PIX_W-1:0] threshold;
  logic             frame_done;
  logic             drain_dbg;

  modport master (
    output in_valid, pix_data, mode, border_en,
    input  out_valid, bin, threshold, frame_done, drain_dbg
  );

  modport slave (
    input  in_valid, pix_data, mode, border_en,
    output out_valid, bin, threshold, frame_done, drain_dbg
  );
endinterface

// File: rtl/ate_stream.sv
// Block-ordered adaptive threshold: accumulates one BLKxBLK block into a
// ping-pong buffer while the previous block drains as binarised pixels.
module ate_stream #(
  parameter int PIX_W    = 8,
  parameter int BLK      = 8,
  parameter int BLK_COLS = 6,
  parameter int BLK_ROWS = 4
) (
  input  logic          clk,
  input  logic          reset,
  ate_stream_if.slave   s
);

  localparam int LOG_B = $clog2(BLK);
  localparam int N     = BLK * BLK;
  localparam int IW    = 2 * LOG_B;
  localparam int SW    = PIX_W + IW;
  localparam int CW    = $clog2(BLK_COLS);
  localparam int RW    = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } drain_state_t;

  // ---------------- accept-side position counters ----------------
  logic [IW-1:0] pix_idx_q;
  logic [CW-1:0] blk_col_q;
  logic [RW-1:0] blk_row_q;
  logic          wr_bank_q;

  logic pix_last;
  logic col_last;
  logic row_last;
  logic blk_done;

  always_comb begin
    pix_last = (pix_idx_q == IW'(N - 1));
    col_last = (blk_col_q == CW'(BLK_COLS - 1));
    row_last = (blk_row_q == RW'(BLK_ROWS - 1));
    blk_done = s.in_valid && pix_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_idx_q <= '0;
      blk_col_q <= '0;
      blk_row_q <= '0;
      wr_bank_q <= 1'b0;
    end else if (s.in_valid) begin
      pix_idx_q <= pix_idx_q + IW'(1);
      if (pix_last) begin
        wr_bank_q <= ~wr_bank_q;
        if (col_last) begin
          blk_col_q <= '0;
          blk_row_q <= row_last ? '0 : blk_row_q + RW'(1);
        end else begin
          blk_col_q <= blk_col_q + CW'(1);
        end
      end
    end
  end

  // ---------------- ping-pong pixel buffer ----------------
  // The bank being drained is always the one not being written, so no
  // read/write arbitration is needed.
  logic [PIX_W-1:0] pix_buf [2*N];

  always_ff @(posedge clk) begin
    if (s.in_valid) begin
      pix_buf[{wr_bank_q, pix_idx_q}] <= s.pix_data;
    end
  end

  // ---------------- running block statistics ----------------
  logic [PIX_W-1:0] min_q, max_q, min_n, max_n;
  logic [SW-1:0]    sum_q, sum_n;
  logic             first_pix;

  always_comb begin
    first_pix = (pix_idx_q == '0);
    min_n     = min_q;
    max_n     = max_q;
    sum_n     = sum_q;
    if (first_pix || (s.pix_data < min_q)) min_n = s.pix_data;
    if (first_pix || (s.pix_data > max_q)) max_n = s.pix_data;
    sum_n = (first_pix ? '0 : sum_q) + SW'(s.pix_data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (s.in_valid) begin
      min_q <= min_n;
      max_q <= max_n;
      sum_q <= sum_n;
    end
  end

  // ---------------- threshold of the completing block ----------------
  // Both forms round half up; the mean one-bit headroom keeps the +N/2
  // from overflowing before the shift.
  logic [PIX_W-1:0] mid_thr;
  logic [PIX_W-1:0] mean_thr;
  logic             blk_border;
  logic [PIX_W-1:0] blk_thr;

  always_comb begin
    mid_thr    = PIX_W'(({1'b0, min_n} + {1'b0, max_n} + (PIX_W+1)'(1)) >> 1);
    mean_thr   = PIX_W'(({1'b0, sum_n} + (SW+1)'(N / 2)) >> IW);
    blk_border = s.border_en && ((blk_col_q == '0) || col_last);
    blk_thr    = blk_border ? '0 : (s.mode ? mean_thr : mid_thr);
  end

  // ---------------- drain FSM ----------------
  drain_state_t     state_q, state_n;
  logic [IW-1:0]    rd_idx_q;
  logic [PIX_W-1:0] drain_thr_q;
  logic             drain_sup_q;
  logic             drain_eof_q;
  logic [PIX_W-1:0] rd_data;
  logic             rd_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    rd_last      = (rd_idx_q == IW'(N - 1));
    rd_data      = pix_buf[{~wr_bank_q, rd_idx_q}];
    s.out_valid  = 1'b0;
    s.bin        = 1'b0;
    s.threshold  = '0;
    s.frame_done = 1'b0;
    s.drain_dbg  = (state_q == S_DRAIN);
    case (state_q)
      S_IDLE: begin
        if (blk_done) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        s.out_valid  = 1'b1;
        s.bin        = !drain_sup_q && (rd_data >= drain_thr_q);
        s.threshold  = drain_thr_q;
        s.frame_done = drain_eof_q && rd_last;
        // A block completing on the final drain cycle chains straight on.
        if (rd_last && !blk_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_idx_q    <= '0;
      drain_thr_q <= '0;
      drain_sup_q <= 1'b0;
      drain_eof_q <= 1'b0;
    end else if (blk_done) begin
      rd_idx_q    <= '0;
      drain_thr_q <= blk_thr;
      drain_sup_q <= blk_border;
      drain_eof_q <= col_last && row_last;
    end else if (state_q == S_DRAIN) begin
      rd_idx_q <= rd_idx_q + IW'(1);
    end
  end

endmodule

// File: tb/tb_ate_stream.sv
// Directed-plus-random bench for ate_stream: each block's expected outputs
// and their exact cycles come from a reference model of the block rules.
module tb_ate_stream;

  localparam int PIX_W    = 8;
  localparam int BLK      = 8;
  localparam int BLK_COLS = 6;
  localparam int BLK_ROWS = 4;
  localparam int N        = BLK * BLK;
  localparam int EW       = 32 + 2 + PIX_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ate_stream_if #(.PIX_W(PIX_W)) sif ();

  ate_stream #(
    .PIX_W(PIX_W), .BLK(BLK), .BLK_COLS(BLK_COLS), .BLK_ROWS(BLK_ROWS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s     (sif)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  int blk_k    = 0;

  logic [EW-1:0]    exp_q[$];
  logic [PIX_W-1:0] blk_pix [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_block(input bit md, input bit be, input int n);
    int mn, mx, sum, thr, col, row;
    bit sup, eof;
    mn  = int'(blk_pix[0]);
    mx  = mn;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(blk_pix[i]) < mn) mn = int'(blk_pix[i]);
      if (int'(blk_pix[i]) > mx) mx = int'(blk_pix[i]);
      sum += int'(blk_pix[i]);
    end
    col = blk_k % BLK_COLS;
    row = (blk_k / BLK_COLS) % BLK_ROWS;
    sup = be && (col == 0 || col == BLK_COLS - 1);
    eof = (row == BLK_ROWS - 1) && (col == BLK_COLS - 1);
    if (sup)     thr = 0;
    else if (md) thr = (sum + N / 2) / N;
    else         thr = (mn + mx + 1) / 2;
    for (int j = 0; j < N; j++) begin
      bit b, f;
      b = !sup && (int'(blk_pix[j]) >= thr);
      f = eof && (j == N - 1);
      exp_q.push_back({32'(n + j), f, b, PIX_W'(thr)});
    end
    blk_k++;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (sif.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_cycle",  64'(cyc),        64'(e[EW-1 -: 32]));
        chk("bin",        64'(sif.bin),    64'(e[PIX_W]));
        chk("threshold",  64'(sif.threshold), 64'(e[PIX_W-1:0]));
        chk("frame_done", 64'(sif.frame_done), 64'(e[PIX_W+1]));
      end
      if (sif.frame_done === 1'b1) fd_count++;
    end else begin
      chk("idle_zero", 64'({sif.out_valid, sif.bin, sif.threshold, sif.frame_done}), 64'(0));
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
        chk("missing_out", 64'(cyc), 64'(exp_q[0][EW-1 -: 32]));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    sif.in_valid  = 1'b0;
    sif.pix_data  = PIX_W'($urandom);
    sif.mode      = 1'($urandom);
    sif.border_en = 1'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic send_block(input bit md, input bit be, input int gap_pct);
    for (int p = 0; p < N; p++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle_cycle();
      sif.in_valid  = 1'b1;
      sif.pix_data  = blk_pix[p];
      sif.mode      = (p == N - 1) ? md : 1'($urandom);
      sif.border_en = (p == N - 1) ? be : 1'($urandom);
      @(posedge clk); #1;
    end
    sif.in_valid = 1'b0;
    model_block(md, be, cyc);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) blk_pix[i] = PIX_W'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(sif.out_valid),  64'(0));
    chk({tag, "_bin"},   64'(sif.bin),        64'(0));
    chk({tag, "_thr"},   64'(sif.threshold),  64'(0));
    chk({tag, "_fd"},    64'(sif.frame_done), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    blk_k = 0;
    #1;
    check_outputs_zero("reset");
    idle_cycle();
    idle_cycle();
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    idle_cycle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sif.in_valid  = 1'b0;
    sif.pix_data  = '0;
    sif.mode      = 1'b0;
    sif.border_en = 1'b0;
    #1;
    check_outputs_zero("por");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycle();

    // midrange with border on: col 0 suppressed, ramp block gives 42
    fill_rand();
    send_block(1'b0, 1'b1, 0);
    for (int i = 0; i < N; i++) blk_pix[i] = PIX_W'(10 + i);
    send_block(1'b0, 1'b1, 0);
    // mean with a single bright pixel
    for (int i = 0; i < N; i++) blk_pix[i] = '0;
    blk_pix[5] = PIX_W'(255);
    send_block(1'b1, 1'b1, 0);
    wait_drain();

    // border off on column 0
    do_reset();
    for (int i = 0; i < N; i++) blk_pix[i] = PIX_W'(200 - i);
    send_block(1'b0, 1'b0, 0);
    wait_drain();

    // first scenario again with 50% input gaps
    do_reset();
    fill_rand();
    send_block(1'b0, 1'b1, 50);
    for (int i = 0; i < N; i++) blk_pix[i] = PIX_W'(10 + i);
    send_block(1'b0, 1'b1, 50);
    wait_drain();

    // full frame plus one block back-to-back
    do_reset();
    fd_count = 0;
    for (int b = 0; b < BLK_ROWS * BLK_COLS + 1; b++) begin
      fill_rand();
      send_block(1'($urandom), 1'b1, 0);
    end
    wait_drain();
    chk("frame_done_count", 64'(fd_count), 64'(1));

    // random blocks, random modes and gaps
    for (int b = 0; b < 10; b++) begin
      fill_rand();
      send_block(1'($urandom), 1'($urandom), $urandom_range(0, 60));
    end
    wait_drain();

    // reset during output 20 with a partial block in flight
    do_reset();
    for (int b = 0; b < 3; b++) begin
      fill_rand();
      send_block(1'b0, 1'b1, 0);
    end
    for (int p = 0; p < 20; p++) begin
      sif.in_valid = 1'b1;
      sif.pix_data = PIX_W'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    exp_q.delete();
    blk_k = 0;
    #1;
    check_outputs_zero("mid_drain_reset");
    idle_cycle();
    idle_cycle();
    reset = 1'b0;
    repeat (10) idle_cycle();
    fill_rand();
    send_block(1'b0, 1'b1, 0);
    fill_rand();
    send_block(1'b1, 1'b1, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
